// File: rtl/plane_hit_prep.sv
// plane_hit_prep
// Operand preparation for the ray/plane intersection divide. For one operand
// set it forms the numerator dot(n, p - o) and the denominator dot(n, d) in
// signed fixed point with Q_BITS fractional bits. It saturates both to
// D_WIDTH bits and flags rays whose denominator magnitude is below EPS.
//
// Parameters
//   Q_BITS   fractional bits of every operand and result
//   D_WIDTH  width of every data port
//   EPS      parallel threshold in raw LSBs
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   ox..oz, dx..dz          ray origin and direction (signed)
//   nx..nz, px..pz          plane normal and point on plane (signed)
//   in_valid / in_ready     operand-set handshake (ready only when idle)
//   dividend, divisor       saturated dot products
//   parallel                |divisor| < EPS
//   out_valid / out_ready   result handshake; outputs held until taken
module plane_hit_prep #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32,
  parameter int EPS     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [D_WIDTH-1:0] ox,
  input  logic signed [D_WIDTH-1:0] oy,
  input  logic signed [D_WIDTH-1:0] oz,
  input  logic signed [D_WIDTH-1:0] dx,
  input  logic signed [D_WIDTH-1:0] dy,
  input  logic signed [D_WIDTH-1:0] dz,
  input  logic signed [D_WIDTH-1:0] nx,
  input  logic signed [D_WIDTH-1:0] ny,
  input  logic signed [D_WIDTH-1:0] nz,
  input  logic signed [D_WIDTH-1:0] px,
  input  logic signed [D_WIDTH-1:0] py,
  input  logic signed [D_WIDTH-1:0] pz,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [D_WIDTH-1:0] dividend,
  output logic signed [D_WIDTH-1:0] divisor,
  output logic                      parallel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Product of a D_WIDTH normal component and a D_WIDTH+1 difference term.
  localparam int PROD_W = 2 * D_WIDTH + 1;
  // Two guard bits above the product width so a 3-term sum never wraps.
  localparam int ACC_W  = 2 * D_WIDTH + 3;

  localparam logic [D_WIDTH:0] EPS_W = (D_WIDTH + 1)'(EPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX_EXT =
    {{(ACC_W - D_WIDTH + 1){1'b0}}, {(D_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN_EXT =
    {{(ACC_W - D_WIDTH + 1){1'b1}}, {(D_WIDTH - 1){1'b0}}};
  localparam logic signed [D_WIDTH-1:0] SAT_MAX = {1'b0, {(D_WIDTH - 1){1'b1}}};
  localparam logic signed [D_WIDTH-1:0] SAT_MIN = {1'b1, {(D_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    NUM,
    DEN,
    DONE
  } state_t;

  state_t state;
  logic [1:0] term_cnt;

  logic signed [D_WIDTH-1:0] ox_q, oy_q, oz_q;
  logic signed [D_WIDTH-1:0] dx_q, dy_q, dz_q;
  logic signed [D_WIDTH-1:0] nx_q, ny_q, nz_q;
  logic signed [D_WIDTH-1:0] px_q, py_q, pz_q;

  logic signed [D_WIDTH:0] ex, ey, ez;

  logic signed [ACC_W-1:0] acc_num;
  logic signed [ACC_W-1:0] acc_den;

  logic signed [D_WIDTH-1:0] mul_a;
  logic signed [D_WIDTH:0]   mul_b;
  logic signed [PROD_W-1:0]  product;
  logic signed [PROD_W-1:0]  product_shifted;
  logic signed [ACC_W-1:0]   product_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [D_WIDTH-1:0] sum_sat;
  logic signed [D_WIDTH:0]   sat_ext;
  logic        [D_WIDTH:0]   sat_abs;
  logic                      sat_parallel;

  function automatic logic signed [D_WIDTH-1:0] saturate(
    input logic signed [ACC_W-1:0] value
  );
    if (value > SAT_MAX_EXT) begin
      return SAT_MAX;
    end else if (value < SAT_MIN_EXT) begin
      return SAT_MIN;
    end else begin
      return value[D_WIDTH-1:0];
    end
  endfunction

  // The single shared multiplier. The normal component is always the first
  // operand. The second is the registered difference term while in NUM and the
  // sign-extended direction component while in DEN.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (term_cnt)
      2'd0: begin
        mul_a = nx_q;
        mul_b = (state == NUM) ? ex : {dx_q[D_WIDTH-1], dx_q};
      end
      2'd1: begin
        mul_a = ny_q;
        mul_b = (state == NUM) ? ey : {dy_q[D_WIDTH-1], dy_q};
      end
      2'd2: begin
        mul_a = nz_q;
        mul_b = (state == NUM) ? ez : {dz_q[D_WIDTH-1], dz_q};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // Arithmetic shift floors toward negative infinity, so a tiny negative
  // product contributes -1 LSB rather than 0.
  assign product         = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign product_shifted = product >>> Q_BITS;
  assign product_ext     = ACC_W'(product_shifted);
  assign acc_sum         = ((state == DEN) ? acc_den : acc_num) + product_ext;

  // The parallel test uses the saturated value. Its magnitude is taken one bit
  // wider so that the most negative value does not overflow on negation.
  assign sum_sat      = saturate(acc_sum);
  assign sat_ext      = (D_WIDTH + 1)'(sum_sat);
  assign sat_abs      = sat_ext[D_WIDTH] ? -sat_ext : sat_ext;
  assign sat_parallel = (sat_abs < EPS_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      term_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dividend  <= '0;
      divisor   <= '0;
      parallel  <= 1'b0;
      acc_num   <= '0;
      acc_den   <= '0;
      ex        <= '0;
      ey        <= '0;
      ez        <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      oz_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      nz_q      <= '0;
      px_q      <= '0;
      py_q      <= '0;
      pz_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ox_q     <= ox;
            oy_q     <= oy;
            oz_q     <= oz;
            dx_q     <= dx;
            dy_q     <= dy;
            dz_q     <= dz;
            nx_q     <= nx;
            ny_q     <= ny;
            nz_q     <= nz;
            px_q     <= px;
            py_q     <= py;
            pz_q     <= pz;
            in_ready <= 1'b0;
            state    <= DIFF;
          end
        end

        // The differences are one bit wider than the operands, so p - o is
        // exact for any pair of inputs.
        DIFF: begin
          ex       <= (D_WIDTH + 1)'(px_q) - (D_WIDTH + 1)'(ox_q);
          ey       <= (D_WIDTH + 1)'(py_q) - (D_WIDTH + 1)'(oy_q);
          ez       <= (D_WIDTH + 1)'(pz_q) - (D_WIDTH + 1)'(oz_q);
          acc_num  <= '0;
          acc_den  <= '0;
          term_cnt <= '0;
          state    <= NUM;
        end

        NUM: begin
          acc_num <= acc_sum;
          if (term_cnt == 2'd2) begin
            dividend <= sum_sat;
            term_cnt <= '0;
            state    <= DEN;
          end else begin
            term_cnt <= term_cnt + 2'd1;
          end
        end

        DEN: begin
          acc_den <= acc_sum;
          if (term_cnt == 2'd2) begin
            divisor   <= sum_sat;
            parallel  <= sat_parallel;
            out_valid <= 1'b1;
            term_cnt  <= '0;
            state     <= DONE;
          end else begin
            term_cnt <= term_cnt + 2'd1;
          end
        end

        // in_ready comes back with the IDLE state. It is therefore never high
        // on the edge that completes the result handshake.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          term_cnt  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plane_hit_prep.sv
// tb_plane_hit_prep
// Scoreboard bench for plane_hit_prep (Q_BITS=10, D_WIDTH=32, EPS=1).
// Expected results come from a wide-integer model. They are queued when an
// operand set is driven and compared when the DUT completes a result handshake.
module tb_plane_hit_prep;

  localparam int Q = 10;

  typedef struct packed {
    logic signed [31:0] ox, oy, oz;
    logic signed [31:0] dx, dy, dz;
    logic signed [31:0] nx, ny, nz;
    logic signed [31:0] px, py, pz;
  } ops_t;

  typedef struct packed {
    logic signed [31:0] dividend;
    logic signed [31:0] divisor;
    logic               parallel;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic signed [31:0] ox, oy, oz, dx, dy, dz, nx, ny, nz, px, py, pz;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, parallel, out_valid;
  logic signed [31:0] dividend, divisor;

  int checks = 0;
  int errors = 0;
  res_t expq[$];

  plane_hit_prep #(.Q_BITS(10), .D_WIDTH(32), .EPS(1)) dut (
    .clock(clock), .reset(reset),
    .ox(ox), .oy(oy), .oz(oz),
    .dx(dx), .dy(dy), .dz(dz),
    .nx(nx), .ny(ny), .nz(nz),
    .px(px), .py(py), .pz(pz),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .parallel(parallel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic signed [31:0] sat32(input logic signed [127:0] v);
    if (v > 128'sh7FFF_FFFF) return 32'sh7FFF_FFFF;
    if (v < -128'sh8000_0000) return 32'sh8000_0000;
    return v[31:0];
  endfunction

  function automatic res_t model(input ops_t op);
    logic signed [127:0] ex, ey, ez, n0, n1, n2, d0, d1, d2, num, den, a;
    res_t r;
    logic signed [127:0] wpx, wpy, wpz, wox, woy, woz;
    wpx = op.px; wpy = op.py; wpz = op.pz;
    wox = op.ox; woy = op.oy; woz = op.oz;
    n0 = op.nx; n1 = op.ny; n2 = op.nz;
    d0 = op.dx; d1 = op.dy; d2 = op.dz;
    ex = wpx - wox; ey = wpy - woy; ez = wpz - woz;
    num = ((n0 * ex) >>> Q) + ((n1 * ey) >>> Q) + ((n2 * ez) >>> Q);
    den = ((n0 * d0) >>> Q) + ((n1 * d1) >>> Q) + ((n2 * d2) >>> Q);
    r.dividend = sat32(num);
    r.divisor  = sat32(den);
    a = r.divisor;
    if (a < 0) a = -a;
    r.parallel = (a < 1);
    return r;
  endfunction

  function automatic ops_t mkOps(input int o_z, input int d_x, input int d_z,
                                 input int n_z, input int p_z);
    ops_t op;
    op = '0;
    op.oz = o_z; op.dx = d_x; op.dz = d_z; op.nz = n_z; op.pz = p_z;
    return op;
  endfunction

  task automatic driveOps(input ops_t op);
    ox = op.ox; oy = op.oy; oz = op.oz;
    dx = op.dx; dy = op.dy; dz = op.dz;
    nx = op.nx; ny = op.ny; nz = op.nz;
    px = op.px; py = op.py; pz = op.pz;
  endtask

  task automatic scrambleInputs();
    ox = $urandom; oy = $urandom; oz = $urandom;
    dx = $urandom; dy = $urandom; dz = $urandom;
    nx = $urandom; ny = $urandom; nz = $urandom;
    px = $urandom; py = $urandom; pz = $urandom;
  endtask

  // Waits for in_ready, presents the set for one accepting edge, then garbles
  // the operand inputs so that any late sampling would show up in the results.
  task automatic applyStimulus(input ops_t op, input bit push);
    int k;
    k = 0;
    @(negedge clock);
    while (!in_ready && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 64'(in_ready), 64'd1);
    driveOps(op);
    in_valid = 1'b1;
    if (push) expq.push_back(model(op));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    scrambleInputs();
  endtask

  task automatic waitOutValid(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // The scoreboard pops one entry per completed result handshake.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checkOutput("sb_unexpected", 64'd1, 64'd0);
      end else begin
        res_t e;
        e = expq.pop_front();
        checkOutput("sb_dividend", dividend, e.dividend);
        checkOutput("sb_divisor", divisor, e.divisor);
        checkOutput("sb_parallel", 64'(parallel), 64'(e.parallel));
      end
    end
  end

  task automatic runOp(input ops_t op);
    int lat;
    out_ready = 1'b1;
    applyStimulus(op, 1'b1);
    waitOutValid(lat);
    checkOutput("latency", lat, 8);
    @(negedge clock);
    checkOutput("one_cycle_valid", 64'(out_valid), 64'd0);
    checkOutput("ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    ops_t v1, op, op2;
    res_t e;
    int lat;

    driveOps('0);
    #3;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_dividend", dividend, 32'sd0);
    checkOutput("rst_divisor", divisor, 32'sd0);
    checkOutput("rst_parallel", 64'(parallel), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    v1 = mkOps(0, 0, 1024, 1024, 5120);
    runOp(v1);
    runOp(mkOps(0, 1024, 0, 1024, 5120));
    runOp(mkOps(0, 0, -2048, -1024, 5120));
    runOp(mkOps(0, 0, 1, -1, 0));
    runOp(mkOps(32'sh8000_0000, 0, 1024, 4096, 32'sh7FFF_FFFF));
    runOp(mkOps(32'sh7FFF_FFFF, 0, 1024, 4096, 32'sh8000_0000));

    // Hold off the consumer in DONE, and queue a back-to-back operand set.
    out_ready = 1'b0;
    e = model(v1);
    applyStimulus(v1, 1'b1);
    waitOutValid(lat);
    checkOutput("hold_latency", lat, 8);
    op2 = mkOps(100, 0, 3072, 2048, -7000);
    op2.nx = 512; op2.px = 4096; op2.dx = -1024;
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clock);
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_dividend", dividend, e.dividend);
      checkOutput("hold_divisor", divisor, e.divisor);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      if (h == 2) begin
        driveOps(op2);
        in_valid = 1'b1;
        expq.push_back(model(op2));
      end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
    checkOutput("b2b_valid_low", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    scrambleInputs();
    waitOutValid(lat);
    checkOutput("b2b_latency", lat, 8);
    @(negedge clock);

    // Reset while the numerator is being accumulated (term counter = 1).
    applyStimulus(v1, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_valid) lat++;
    end
    checkOutput("abort_no_result", lat, 0);
    runOp(v1);

    for (int i = 0; i < 8; i++) begin
      op.ox = $urandom; op.oy = $urandom; op.oz = $urandom;
      op.px = $urandom; op.py = $urandom; op.pz = $urandom;
      op.dx = $urandom; op.dy = $urandom; op.dz = $urandom;
      if (i < 4) begin
        op.nx = $urandom_range(0, 8191) - 4096;
        op.ny = $urandom_range(0, 8191) - 4096;
        op.nz = $urandom_range(0, 8191) - 4096;
        op.dx = $urandom_range(0, 8191) - 4096;
        op.dy = $urandom_range(0, 8191) - 4096;
        op.dz = $urandom_range(0, 8191) - 4096;
        op.ox = $urandom_range(0, 65535) - 32768;
        op.pz = $urandom_range(0, 65535) - 32768;
      end else begin
        op.nx = $urandom; op.ny = $urandom; op.nz = $urandom;
      end
      runOp(op);
    end

    checkOutput("sb_drain", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plane_hit_prep.md
PLANE_HIT_PREP -- requirements
Module: plane_hit_prep
Upstream operand stage for the ray tracer's fixed-point divider: computes t = dot(n, p-o) / dot(n, d) numerator and denominator.

Interface
REQ-001 Parameter Q_BITS, default 10, number of fractional bits of every signed fixed-point operand and result.
REQ-002 Parameter D_WIDTH, default 32, width of every data port.
REQ-003 Parameter EPS, default 1, parallel threshold in raw LSBs; |divisor| < EPS flags the ray as parallel.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ox, oy, oz  input  D_WIDTH each  signed ray origin.
REQ-007 dx, dy, dz  input  D_WIDTH each  signed ray direction.
REQ-008 nx, ny, nz  input  D_WIDTH each  signed plane normal.
REQ-009 px, py, pz  input  D_WIDTH each  signed point on plane.
REQ-010 in_valid  input  1  operand set present.
REQ-011 in_ready  output  1  block can accept an operand set.
REQ-012 dividend  output  D_WIDTH  signed dot(n, p-o), saturated.
REQ-013 divisor  output  D_WIDTH  signed dot(n, d), saturated.
REQ-014 parallel  output  1  |divisor| < EPS; qualifies dividend/divisor.
REQ-015 out_valid  output  1  dividend, divisor and parallel are valid.
REQ-016 out_ready  input  1  consumer accepts the result.

Function
REQ-017 The block SHALL be an FSM with states IDLE, DIFF, NUM, DEN, DONE, plus a 2-bit term counter.
REQ-018 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge, which registers all 12 operands and enters DIFF.
REQ-019 DIFF (1 cycle) SHALL register ex=px-ox, ey=py-oy, ez=pz-oz at D_WIDTH+1 bits with no overflow, and clear the accumulator.
REQ-020 NUM (3 cycles, counter 0..2) SHALL add one product per cycle: nx*ex, then ny*ey, then nz*ez.
REQ-021 DEN (3 cycles, counter 0..2) SHALL add nx*dx, then ny*dy, then nz*dz into a separately cleared accumulator.
REQ-022 Exactly one multiplier SHALL be instantiated and shared across all six products.
REQ-023 Each full-width product SHALL be arithmetically right-shifted by Q_BITS (floor toward negative infinity) before accumulation.
REQ-024 Accumulators SHALL be 2*D_WIDTH+3 bits so no intermediate sum wraps.
REQ-025 The sums SHALL saturate to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1] when registered into dividend/divisor.
REQ-026 parallel SHALL be computed from the saturated divisor.
REQ-027 out_valid SHALL be 1 only in DONE and SHALL first rise in the 8th cycle after the accepting edge.
REQ-028 In DONE, dividend, divisor and parallel SHALL remain stable until out_ready is sampled high.
REQ-029 On that edge the FSM SHALL return to IDLE; in_ready rises the following cycle, so there is no same-cycle re-accept.
REQ-030 A parallel result SHALL still be presented with out_valid=1; the consumer decides whether to launch the divide.
REQ-031 Inputs SHALL be ignored outside IDLE, and in_valid dropping mid-operation SHALL have no effect.
REQ-032 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-033 On reset the FSM SHALL enter IDLE, and counter, accumulators, dividend, divisor, parallel and out_valid SHALL be 0; in_ready SHALL be 1 once reset deasserts.
REQ-034 Reset asserted in any state, including mid-accumulation or in DONE, SHALL abort the operation with no result presented.

Verification (Q_BITS=10, 1.0=1024)
V-1 n=(0,0,1024), p=(0,0,5120), o=0, d=(0,0,1024), out_ready=1 -> dividend=5120, divisor=1024, parallel=0, out_valid in the 8th cycle after accept for exactly 1 cycle.
V-2 Same as V-1 but d=(1024,0,0) -> divisor=0, parallel=1, out_valid=1.
V-3 n=(0,0,-1024), p=(0,0,5120), o=0, d=(0,0,-2048) -> dividend=-5120, divisor=2048; product floor check: n=(0,0,-1), d=(0,0,1) -> divisor=-1.
V-4 pz=0x7FFFFFFF, oz=0x80000000, n=(0,0,4096) -> dividend=0x7FFFFFFF (saturated); oz=pz swapped -> dividend=0x80000000.
V-5 V-1 with out_ready low 5 cycles -> out_valid high and outputs stable 5 cycles; in_ready low throughout; back-to-back in_valid accepted only the cycle after the DONE handshake.
V-6 Reset asserted during NUM counter=1 -> out_valid=0 immediately, in_ready=1 after release; next V-1 operand set yields V-1 results unaffected.
